ram_responder: RTL and testbench

//  Memory-side responder for the datapath's instruction/data request protocol.

---
 rtl/ram_responder.sv | 118 +++++++++++
 tb/tb_ram_responder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_responder.sv
// ram_responder: word-RAM responder for iREN/dREN/dWEN requests with LAT wait states.
// Define MEM_RESP_STATS_EN to add the ireq_cnt/dreq_cnt completed-access counters.
module ram_responder #(
  parameter int LAT     = 2,
  parameter int DEPTH_W = 10
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ihit,
  output logic        dhit
`ifdef MEM_RESP_STATS_EN
  ,
  output logic [31:0] ireq_cnt,
  output logic [31:0] dreq_cnt
`endif
);

  // state | meaning
  // IDLE  | accepts the highest-priority request (write, data read, instr read)
  // WAIT  | counts down the wait states of the latched access
  // RESP  | one-cycle hit pulse; read data was registered on entry
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {K_IF, K_RD, K_WR} kind_t;

  state_t             state, state_next;
  kind_t              kind, kind_next;
  logic [3:0]         cnt, cnt_next;
  logic [DEPTH_W-1:0] idx, idx_next;
  logic [31:0]        wdata, wdata_next;
  logic               go_resp;
  logic               wr_en;
  logic               unused_addr;

  logic [31:0] mem [0:(1<<DEPTH_W)-1];

  // Only the word index is decoded; the rest of each address aliases.
  assign unused_addr = ^{iaddr[31:DEPTH_W+2], iaddr[1:0], daddr[31:DEPTH_W+2], daddr[1:0]};

  always_comb begin
    state_next = state;
    kind_next  = kind;
    cnt_next   = cnt;
    idx_next   = idx;
    wdata_next = wdata;
    ihit       = 1'b0;
    dhit       = 1'b0;
    case (state)
      IDLE: begin
        if (dWEN || dREN || iREN) begin
          kind_next  = dWEN ? K_WR : (dREN ? K_RD : K_IF);
          idx_next   = (dWEN || dREN) ? daddr[DEPTH_W+1:2] : iaddr[DEPTH_W+1:2];
          wdata_next = dstore;
          cnt_next   = 4'(LAT);
          state_next = (LAT > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_next = cnt - 4'd1;
        if (cnt == 4'd1) state_next = RESP;
      end
      RESP: begin
        state_next = IDLE;
        ihit       = (kind == K_IF);
        dhit       = (kind != K_IF);
      end
      default: state_next = IDLE;
    endcase
    // The *_next values describe the access even when LAT=0 skips WAIT.
    go_resp = (state_next == RESP) && (state != RESP);
    wr_en   = go_resp && (kind_next == K_WR);
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= IDLE;
      kind  <= K_IF;
      cnt   <= '0;
      idx   <= '0;
      wdata <= '0;
      iload <= '0;
      dload <= '0;
    end else begin
      state <= state_next;
      kind  <= kind_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
      wdata <= wdata_next;
      if (go_resp && kind_next == K_RD) dload <= mem[idx_next];
      if (go_resp && kind_next == K_IF) iload <= mem[idx_next];
    end
  end

  // RAM has no reset so its contents survive nRST; a write still in flight is dropped.
  always_ff @(posedge CLK) begin
    if (nRST && wr_en) mem[idx_next] <= wdata_next;
  end

`ifdef MEM_RESP_STATS_EN
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      ireq_cnt <= '0;
      dreq_cnt <= '0;
    end else begin
      if (ihit) ireq_cnt <= ireq_cnt + 32'd1;
      if (dhit) dreq_cnt <= dreq_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: directed and randomized checks of ram_responder against a word-array model.
// Counter checks are compiled in when MEM_RESP_STATS_EN is defined.
module tb_ram_responder;
  localparam int LAT     = 2;
  localparam int DEPTH_W = 10;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic [31:0] iload, dload;
  logic        ihit, dhit;
`ifdef MEM_RESP_STATS_EN
  logic [31:0] ireq_cnt, dreq_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] model_mem [0:(1<<DEPTH_W)-1];
  logic [31:0] last_i, last_d;
  int          mi, md;

  always #5 CLK = ~CLK;

  ram_responder #(.LAT(LAT), .DEPTH_W(DEPTH_W)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iload(iload), .dload(dload), .ihit(ihit), .dhit(dhit)
`ifdef MEM_RESP_STATS_EN
    , .ireq_cnt(ireq_cnt), .dreq_cnt(dreq_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge CLK) check("both_hits", {31'b0, ihit & dhit}, 32'd0);

  function automatic int widx(input logic [31:0] a);
    return int'(a[DEPTH_W+1:2]);
  endfunction

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic wait_hit(output int n, output logic gi, output logic gd);
    n = 0;
    while (!(ihit || dhit) && n < 50) begin
      step();
      n++;
    end
    gi = ihit;
    gd = dhit;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    step();
    nRST = 1'b1;
    last_i = '0;
    last_d = '0;
    mi = 0;
    md = 0;
  endtask

  // kind: 0 instr read, 1 data read, 2 write, 3 dWEN+dREN (acts as write)
  task automatic access(input int kind, input logic [31:0] addr, input logic [31:0] wdata);
    int   n;
    logic gi, gd;
    int   idx;
    idx    = widx(addr);
    iREN   = (kind == 0);
    dREN   = (kind == 1 || kind == 3);
    dWEN   = (kind >= 2);
    iaddr  = (kind == 0) ? addr : $urandom;
    daddr  = (kind == 0) ? $urandom : addr;
    dstore = wdata;
    step();
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = $urandom; daddr = $urandom; dstore = $urandom;
    wait_hit(n, gi, gd);
    check("latency", n, LAT);
    check("hit_kind", {30'b0, gi, gd}, (kind == 0) ? 32'd2 : 32'd1);
    if (kind == 0) begin
      last_i = model_mem[idx];
      mi++;
    end else begin
      if (kind == 1) last_d = model_mem[idx];
      else model_mem[idx] = wdata;
      md++;
    end
    check("iload", iload, last_i);
    check("dload", dload, last_d);
    step();
    check("hit_drop", {30'b0, ihit, dhit}, 32'd0);
  endtask

  initial begin
    int t, td, ti, nh;
    int hits [3];
    logic [31:0] a;
    iREN = 0; dREN = 0; dWEN = 0; iaddr = 0; daddr = 0; dstore = 0;
    nRST = 1'b0;
    step();
    step();
    nRST = 1'b1;
    last_i = '0; last_d = '0; mi = 0; md = 0;
    check("rst_ihit", {31'b0, ihit}, 32'd0);
    check("rst_dhit", {31'b0, dhit}, 32'd0);
    check("rst_iload", iload, 32'd0);
    check("rst_dload", dload, 32'd0);
`ifdef MEM_RESP_STATS_EN
    check("rst_icnt", ireq_cnt, 32'd0);
    check("rst_dcnt", dreq_cnt, 32'd0);
`endif

    // Write then read back, aliasing across upper and byte-offset bits
    access(2, 32'h10, 32'hDEADBEEF);
    access(1, 32'h10, 32'h0);
    check("rd_0x10", dload, 32'hDEADBEEF);
    access(2, 32'h1000, 32'h00000001);
    access(1, 32'h0, 32'h0);
    check("alias_0x1000", dload, 32'h00000001);
    access(1, 32'h13, 32'h0);
    check("alias_0x13", dload, 32'hDEADBEEF);
    access(3, 32'h14, 32'h0BADF00D);
    access(0, 32'h16, 32'h0);
    check("wr_rd_is_write", iload, 32'h0BADF00D);

    // Simultaneous iREN/dREN: data first, instruction LAT+2 cycles later
    iREN = 1; iaddr = 32'h0; dREN = 1; daddr = 32'h10;
    step();
    t = 0; td = -1; ti = -1;
    while (ti < 0 && t < 60) begin
      if (dhit && td < 0) begin td = t; dREN = 0; end
      if (ihit) begin ti = t; iREN = 0; end
      if (ti < 0) begin step(); t++; end
    end
    check("dual_dhit_lat", td, LAT);
    check("dual_ihit_gap", ti - td, LAT + 2);
    check("dual_dload", dload, model_mem[4]);
    check("dual_iload", iload, model_mem[0]);
    last_i = model_mem[0]; last_d = model_mem[4]; mi++; md++;
    step();

    // Held iREN gives back-to-back ihits spaced LAT+2 cycles
    iREN = 1; iaddr = 32'h10;
    step();
    t = 0; nh = 0;
    while (nh < 3 && t < 60) begin
      if (ihit) begin hits[nh] = t; nh++; end
      if (nh == 3) iREN = 0;
      else begin step(); t++; end
    end
    check("held_hits", nh, 3);
    check("held_gap1", hits[1] - hits[0], LAT + 2);
    check("held_gap2", hits[2] - hits[1], LAT + 2);
    check("held_iload", iload, model_mem[4]);
    last_i = model_mem[4]; mi += 3;
    step();

    // Reset during WAIT of a write: write dropped, RAM kept
    access(2, 32'h20, 32'hA5A5A5A5);
    dWEN = 1; daddr = 32'h20; dstore = 32'h12345678;
    step();
    dWEN = 0;
    nRST = 1'b0;
    step();
    check("mid_rst_ihit", {31'b0, ihit}, 32'd0);
    check("mid_rst_dhit", {31'b0, dhit}, 32'd0);
    check("mid_rst_dload", dload, 32'd0);
    check("mid_rst_iload", iload, 32'd0);
`ifdef MEM_RESP_STATS_EN
    check("mid_rst_dcnt", dreq_cnt, 32'd0);
`endif
    step();
    check("mid_rst_quiet", {30'b0, ihit, dhit}, 32'd0);
    nRST = 1'b1;
    last_i = '0; last_d = '0; mi = 0; md = 0;
    access(1, 32'h20, 32'h0);
    check("rst_dropped_wr", dload, 32'hA5A5A5A5);

    // Randomized traffic over 16 aliased words
    for (int i = 0; i < 16; i++) access(2, 32'(i) << 2, $urandom);
    for (int i = 0; i < 150; i++) begin
      a = $urandom;
      a[DEPTH_W+1:2] = DEPTH_W'($urandom_range(0, 15));
      access($urandom_range(0, 3), a, $urandom);
    end

`ifdef MEM_RESP_STATS_EN
    check("icnt", ireq_cnt, 32'(mi));
    check("dcnt", dreq_cnt, 32'(md));
    do_reset();
    check("icnt_rst", ireq_cnt, 32'd0);
    check("dcnt_rst", dreq_cnt, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
